// File: rtl/pipelined_adder.sv
// Pipelined ripple-chunk adder: stage k adds chunk k of a/b plus the carry
// registered by stage k-1, under a valid/ready handshake with global stall.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             propagate,
   output logic             overflow
);

   localparam int CW = WIDTH / STAGES;

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // A valid result that is not taken stalls every stage; in_ready is the
   // combinational inverse of that stall.
   logic stall;

   logic             valid_q [STAGES];
   logic             valid_d [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic             prop_q  [STAGES];
   logic             prop_d  [STAGES];
   logic             ovf_q;
   logic             ovf_d;

   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic [WIDTH-1:0] sum_s;
   logic             c_s;
   logic             p_s;
   logic             v_s;
   logic [CW:0]      chunk;

   assign stall    = valid_q[STAGES-1] & ~out_ready;
   assign in_ready = ~stall;

   always_comb begin
      a_s   = a;
      b_s   = b;
      sum_s = '0;
      c_s   = cin;
      p_s   = 1'b1;
      v_s   = in_valid;
      chunk = '0;
      ovf_d = ovf_q;
      for (int k = 0; k < STAGES; k++) begin
         chunk = {1'b0, a_s[k*CW +: CW]} + {1'b0, b_s[k*CW +: CW]} + {{CW{1'b0}}, c_s};
         valid_d[k] = valid_q[k];
         a_d[k]     = a_q[k];
         b_d[k]     = b_q[k];
         sum_d[k]   = sum_q[k];
         carry_d[k] = carry_q[k];
         prop_d[k]  = prop_q[k];
         if (!stall) begin
            valid_d[k]             = v_s;
            a_d[k]                 = a_s;
            b_d[k]                 = b_s;
            sum_d[k]               = sum_s;
            sum_d[k][k*CW +: CW]   = chunk[CW-1:0];
            carry_d[k]             = chunk[CW];
            prop_d[k]              = p_s & (&(a_s[k*CW +: CW] ^ b_s[k*CW +: CW]));
            // Carry into the MSB is recovered as a^b^sum at that bit.
            if (k == STAGES-1)
               ovf_d = a_s[WIDTH-1] ^ b_s[WIDTH-1] ^ sum_d[k][WIDTH-1] ^ chunk[CW];
         end
         a_s   = a_q[k];
         b_s   = b_q[k];
         sum_s = sum_q[k];
         c_s   = carry_q[k];
         p_s   = prop_q[k];
         v_s   = valid_q[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
            prop_q[k]  <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
            prop_q[k]  <= prop_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign propagate = prop_q[STAGES-1];
   assign overflow  = ovf_q;

endmodule
